// File: rtl/sprite_pkg.sv
// Shared definitions for the battle-scene sprite controllers.
//   cmd_op_t  : command opcodes carried on cmd_op_in
//   state_t   : back-sprite animation states
//   SPRITE_W  : sheet column pitch in pixels
//   SHEET_COLS: number of sprites in the sheet
//   sheet_x() : sheet x offset of a sprite index
package sprite_pkg;

    localparam int SPRITE_W   = 132;
    localparam int SHEET_COLS = 7;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_SHOW  = 2'd1,
        CMD_FAINT = 2'd2,
        CMD_HIDE  = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_HIDDEN   = 2'd0,
        ST_SLIDE_IN = 2'd1,
        ST_IDLE     = 2'd2,
        ST_FAINT    = 2'd3
    } state_t;

    // Largest offset is 6*132 = 792, so 10 bits never overflow.
    function automatic logic [9:0] sheet_x(input logic [2:0] index);
        return 10'(index) * 10'(SPRITE_W);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Vblank-edge detector shared by the animation controllers.
//   pixel_clk_in   : pixel clock
//   rst_in         : synchronous active-high reset
//   hcount_in      : display horizontal counter
//   vcount_in      : display vertical counter
//   frame_tick_out : one-cycle pulse on the first pixel of vblank
module frame_tick_gen #(
    parameter int VBLANK_LINE = 768
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic        frame_tick_out
);

    logic at_vblank;
    logic at_vblank_q;

    assign at_vblank = (hcount_in == 11'd0) && (vcount_in == 10'(VBLANK_LINE));

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            at_vblank_q <= 1'b0;
        end else begin
            at_vblank_q <= at_vblank;
        end
    end

    // Rising edge only: a stalled counter cannot produce a second tick.
    assign frame_tick_out = at_vblank && !at_vblank_q;

endmodule

// File: rtl/back_sprite_ctrl.sv
// Frame-synchronous sequencer for the player's back sprite.
// Accepts SHOW/FAINT/HIDE commands, runs slide-in, idle-bob and faint
// animations, and updates renderer position / sheet window only on the
// cycle after the vblank tick so a frame never tears.
//   pixel_clk_in, rst_in        : clock, synchronous active-high reset
//   hcount_in, vcount_in        : display counters (vblank detection)
//   cmd_valid_in/cmd_ready_out  : command handshake
//   cmd_op_in, cmd_index_in     : opcode and sprite index (SHOW)
//   x_out, y_out                : renderer screen position
//   sel_x_out, sel_y_out        : renderer sheet window
//   visible_out                 : renderer pixel enable
//   done_out                    : pulse when an animation completes
//   err_out                     : pulse when a command is rejected
module back_sprite_ctrl
    import sprite_pkg::*;
#(
    parameter int HOME_X      = 64,
    parameter int HOME_Y      = 400,
    parameter int START_X     = 0,
    parameter int SLIDE_STEP  = 8,
    parameter int BOB_PERIOD  = 16,
    parameter int BOB_DY      = 2,
    parameter int FAINT_STEP  = 8,
    parameter int FAINT_DY    = 64,
    parameter int VBLANK_LINE = 768
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [1:0]  cmd_op_in,
    input  logic [2:0]  cmd_index_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [9:0]  sel_x_out,
    output logic [8:0]  sel_y_out,
    output logic        visible_out,
    output logic        done_out,
    output logic        err_out
);

    localparam logic [10:0] HOME_X_W     = 11'(HOME_X);
    localparam logic [10:0] START_X_W    = 11'(START_X);
    localparam logic [10:0] SLIDE_STEP_W = 11'(SLIDE_STEP);
    localparam logic [9:0]  HOME_Y_W     = 10'(HOME_Y);
    localparam logic [9:0]  BOB_DY_W     = 10'(BOB_DY);
    localparam logic [9:0]  FAINT_STEP_W = 10'(FAINT_STEP);
    localparam logic [9:0]  FAINT_DY_W   = 10'(FAINT_DY);
    localparam logic [7:0]  BOB_LAST     = 8'(BOB_PERIOD - 1);
    localparam logic [3:0]  COLS_W       = 4'(SHEET_COLS);

    logic frame_tick;

    frame_tick_gen #(
        .VBLANK_LINE (VBLANK_LINE)
    ) u_frame_tick_gen (
        .pixel_clk_in   (pixel_clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .frame_tick_out (frame_tick)
    );

    state_t      state_q,     state_d;
    logic        pend_q,      pend_d;
    cmd_op_t     pend_op_q,   pend_op_d;
    logic [2:0]  pend_idx_q,  pend_idx_d;
    logic [10:0] x_q,         x_d;
    logic [9:0]  y_q,         y_d;
    logic [9:0]  sel_x_q,     sel_x_d;
    logic        visible_q,   visible_d;
    logic        done_q,      done_d;
    logic        err_q,       err_d;
    logic        ready_q,     ready_d;
    logic [7:0]  bob_cnt_q,   bob_cnt_d;
    logic        bob_phase_q, bob_phase_d;
    logic [9:0]  drop_q,      drop_d;

    cmd_op_t     cmd_op;
    logic        accept;
    logic        start_show;

    assign cmd_op = cmd_op_t'(cmd_op_in);
    assign accept = cmd_valid_in && ready_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        pend_d      = pend_q;
        pend_op_d   = pend_op_q;
        pend_idx_d  = pend_idx_q;
        x_d         = x_q;
        y_d         = y_q;
        sel_x_d     = sel_x_q;
        visible_d   = visible_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bob_cnt_d   = bob_cnt_q;
        bob_phase_d = bob_phase_q;
        drop_d      = drop_q;
        start_show  = 1'b0;

        // Apply the command that was pending before this cycle; a command
        // accepted on the tick cycle itself is applied one frame later.
        if (frame_tick) begin
            pend_d = 1'b0;
            unique case (state_q)
                ST_HIDDEN: begin
                    if (pend_q && pend_op_q == CMD_SHOW) begin
                        start_show = 1'b1;
                    end
                end
                ST_SLIDE_IN: begin
                    // Compare before adding so x never overshoots or wraps.
                    if (x_q >= HOME_X_W || (HOME_X_W - x_q) <= SLIDE_STEP_W) begin
                        x_d         = HOME_X_W;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                        bob_cnt_d   = 8'd0;
                        bob_phase_d = 1'b0;
                    end else begin
                        x_d = x_q + SLIDE_STEP_W;
                    end
                end
                ST_IDLE: begin
                    if (pend_q && pend_op_q == CMD_SHOW) begin
                        start_show = 1'b1;
                    end else if (pend_q && pend_op_q == CMD_FAINT) begin
                        y_d     = HOME_Y_W;
                        drop_d  = 10'd0;
                        state_d = ST_FAINT;
                    end else if (pend_q && pend_op_q == CMD_HIDE) begin
                        visible_d = 1'b0;
                        state_d   = ST_HIDDEN;
                    end else begin
                        // Position follows the phase held during this frame;
                        // a toggle on wrap shows up on the next tick.
                        y_d = HOME_Y_W + (bob_phase_q ? BOB_DY_W : 10'd0);
                        if (bob_cnt_q == BOB_LAST) begin
                            bob_cnt_d   = 8'd0;
                            bob_phase_d = !bob_phase_q;
                        end else begin
                            bob_cnt_d = bob_cnt_q + 8'd1;
                        end
                    end
                end
                ST_FAINT: begin
                    y_d    = y_q + FAINT_STEP_W;
                    drop_d = drop_q + FAINT_STEP_W;
                    if ((FAINT_DY_W - drop_q) <= FAINT_STEP_W) begin
                        visible_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_HIDDEN;
                    end
                end
                default: state_d = ST_HIDDEN;
            endcase
        end

        if (start_show) begin
            sel_x_d   = sheet_x(pend_idx_q);
            x_d       = START_X_W;
            y_d       = HOME_Y_W;
            visible_d = 1'b1;
            state_d   = ST_SLIDE_IN;
        end

        // Ready implies HIDDEN/IDLE with nothing pending, and neither state
        // moves on a tick without a pending command, so state_q is stable here.
        if (accept) begin
            unique case (cmd_op)
                CMD_NOP: ;
                CMD_SHOW: begin
                    if (4'(cmd_index_in) >= COLS_W) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d     = 1'b1;
                        pend_op_d  = cmd_op;
                        pend_idx_d = cmd_index_in;
                    end
                end
                CMD_FAINT, CMD_HIDE: begin
                    if (state_q == ST_HIDDEN) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d    = 1'b1;
                        pend_op_d = cmd_op;
                    end
                end
                default: ;
            endcase
        end

        ready_d = (state_d == ST_HIDDEN || state_d == ST_IDLE) && !pend_d;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q     <= ST_HIDDEN;
            pend_q      <= 1'b0;
            pend_op_q   <= CMD_NOP;
            pend_idx_q  <= 3'd0;
            x_q         <= 11'd0;
            y_q         <= 10'd0;
            sel_x_q     <= 10'd0;
            visible_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            bob_cnt_q   <= 8'd0;
            bob_phase_q <= 1'b0;
            drop_q      <= 10'd0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_op_q   <= pend_op_d;
            pend_idx_q  <= pend_idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sel_x_q     <= sel_x_d;
            visible_q   <= visible_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            bob_cnt_q   <= bob_cnt_d;
            bob_phase_q <= bob_phase_d;
            drop_q      <= drop_d;
        end
    end

    assign x_out         = x_q;
    assign y_out         = y_q;
    assign sel_x_out     = sel_x_q;
    assign sel_y_out     = 9'd0;    // single-row sheet
    assign visible_out   = visible_q;
    assign done_out      = done_q;
    assign err_out       = err_q;
    assign cmd_ready_out = ready_q;

endmodule

// File: tb/tb_back_sprite_ctrl.sv
// Self-checking bench for back_sprite_ctrl: a table of directed vectors,
// hand-written multi-frame sequences, then randomized stimulus compared
// against a frame-level reference model.
module tb_back_sprite_ctrl;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in       = 1'b0;
    logic [10:0] hcount_in    = 11'd5;
    logic [9:0]  vcount_in    = 10'd0;
    logic        cmd_valid_in = 1'b0;
    logic        cmd_ready_out;
    logic [1:0]  cmd_op_in    = 2'd0;
    logic [2:0]  cmd_index_in = 3'd0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [9:0]  sel_x_out;
    logic [8:0]  sel_y_out;
    logic        visible_out;
    logic        done_out;
    logic        err_out;

    int n_cmp = 0;
    int n_bad = 0;

    back_sprite_ctrl dut (
        .pixel_clk_in  (pixel_clk_in),
        .rst_in        (rst_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .cmd_valid_in  (cmd_valid_in),
        .cmd_ready_out (cmd_ready_out),
        .cmd_op_in     (cmd_op_in),
        .cmd_index_in  (cmd_index_in),
        .x_out         (x_out),
        .y_out         (y_out),
        .sel_x_out     (sel_x_out),
        .sel_y_out     (sel_y_out),
        .visible_out   (visible_out),
        .done_out      (done_out),
        .err_out       (err_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    // Output snapshot: {sel_y, x, y, sel_x, visible, done, err, ready}
    function automatic logic [43:0] pack(input int x, input int y, input int sx,
                                         input bit v, input bit d, input bit e, input bit r);
        return {9'd0, 11'(x), 10'(y), 10'(sx), v, d, e, r};
    endfunction

    function automatic logic [43:0] dut_outs();
        return {sel_y_out, x_out, y_out, sel_x_out, visible_out, done_out, err_out, cmd_ready_out};
    endfunction

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got sel_y=%0d x=%0d y=%0d sel_x=%0d v/d/e/r=%b, want sel_y=%0d x=%0d y=%0d sel_x=%0d v/d/e/r=%b",
                     name, $time, act[43:35], act[34:24], act[23:14], act[13:4], act[3:0],
                     exp[43:35], exp[34:24], exp[23:14], exp[13:4], exp[3:0]);
        end
    endtask

    // One cycle of stimulus; a tick is always preceded by a quiet cycle so
    // the counters never sit at the vblank point on two consecutive edges.
    task automatic apply(input bit rst, input bit tick, input bit valid,
                         input logic [1:0] op, input logic [2:0] idx);
        if (tick) begin
            @(posedge pixel_clk_in);
            #1;
        end
        rst_in       = rst;
        cmd_valid_in = valid;
        cmd_op_in    = op;
        cmd_index_in = idx;
        hcount_in    = tick ? 11'd0 : 11'd5;
        vcount_in    = tick ? 10'd768 : 10'd0;
        @(posedge pixel_clk_in);
        #1;
        rst_in       = 1'b0;
        cmd_valid_in = 1'b0;
        hcount_in    = 11'd5;
        vcount_in    = 10'd0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        bit          rst;
        bit          tick;
        bit          valid;
        logic [1:0]  op;
        logic [2:0]  idx;
        logic [43:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input bit rst, input bit tick, input bit valid,
                       input logic [1:0] op, input logic [2:0] idx, input logic [43:0] exp);
        vec_t v;
        v.name = name; v.rst = rst; v.tick = tick; v.valid = valid;
        v.op = op; v.idx = idx; v.exp = exp;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    localparam int MD_HIDDEN = 0;
    localparam int MD_SLIDE  = 1;
    localparam int MD_IDLE   = 2;
    localparam int MD_FAINT  = 3;

    int m_mode, m_n, m_pop, m_pidx, m_x, m_y, m_selx;
    bit m_pend, m_vis, m_done, m_err, m_ready;

    task automatic model_reset();
        m_mode = MD_HIDDEN; m_n = 0; m_pend = 0; m_pop = 0; m_pidx = 0;
        m_x = 0; m_y = 0; m_selx = 0;
        m_vis = 0; m_done = 0; m_err = 0; m_ready = 1;
    endtask

    task automatic model_show(input int idx);
        m_selx = idx * 132;
        m_x    = 0;
        m_y    = 400;
        m_vis  = 1;
        m_mode = MD_SLIDE;
        m_n    = 0;
    endtask

    // Advances the model by one clock: slide x = min(8n, 64), idle bob y
    // alternates every 16 frames, faint y = 400 + 8n for n = 1..8.
    task automatic model_step(input bit rst, input bit tick, input bit valid,
                              input int op, input int idx);
        int mode_at_accept;
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        acc = valid && m_ready;
        mode_at_accept = m_mode;
        m_done = 0;
        m_err  = 0;
        if (tick) begin
            if (m_mode == MD_HIDDEN) begin
                if (m_pend && m_pop == 1) model_show(m_pidx);
            end else if (m_mode == MD_SLIDE) begin
                m_n++;
                m_x = 8 * m_n;
                if (m_x >= 64) begin
                    m_x = 64; m_done = 1; m_mode = MD_IDLE; m_n = 0;
                end
            end else if (m_mode == MD_IDLE) begin
                if (m_pend && m_pop == 1) begin
                    model_show(m_pidx);
                end else if (m_pend && m_pop == 2) begin
                    m_mode = MD_FAINT; m_n = 0; m_y = 400;
                end else if (m_pend && m_pop == 3) begin
                    m_vis = 0; m_mode = MD_HIDDEN;
                end else begin
                    m_n++;
                    m_y = 400 + (((m_n - 1) / 16) % 2) * 2;
                end
            end else begin
                m_n++;
                m_y = 400 + 8 * m_n;
                if (8 * m_n >= 64) begin
                    m_vis = 0; m_done = 1; m_mode = MD_HIDDEN;
                end
            end
            m_pend = 0;
        end
        if (acc) begin
            if (op == 1) begin
                if (idx >= 7) m_err = 1;
                else begin m_pend = 1; m_pop = 1; m_pidx = idx; end
            end else if (op == 2 || op == 3) begin
                if (mode_at_accept == MD_HIDDEN) m_err = 1;
                else begin m_pend = 1; m_pop = op; end
            end
        end
        m_ready = (m_mode == MD_HIDDEN || m_mode == MD_IDLE) && !m_pend;
    endtask

    initial begin
        // ---- table: reset, rejects, handshake, show and slide-in ----
        add("reset_state",  1, 0, 0, 2'd0, 3'd0, pack(0, 0, 0, 0, 0, 0, 1));
        add("show_idx7_err",0, 0, 1, 2'd1, 3'd7, pack(0, 0, 0, 0, 0, 1, 1));
        add("faint_hid_err",0, 0, 1, 2'd2, 3'd0, pack(0, 0, 0, 0, 0, 1, 1));
        add("hide_hid_err", 0, 0, 1, 2'd3, 3'd0, pack(0, 0, 0, 0, 0, 1, 1));
        add("nop_accept",   0, 0, 1, 2'd0, 3'd0, pack(0, 0, 0, 0, 0, 0, 1));
        add("tick_empty",   0, 1, 0, 2'd0, 3'd0, pack(0, 0, 0, 0, 0, 0, 1));
        add("show2_accept", 0, 0, 1, 2'd1, 3'd2, pack(0, 0, 0, 0, 0, 0, 0));
        add("show3_blocked",0, 0, 1, 2'd1, 3'd3, pack(0, 0, 0, 0, 0, 0, 0));
        add("show_apply",   0, 1, 0, 2'd0, 3'd0, pack(0, 400, 264, 1, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            add($sformatf("slide_%0d", k), 0, 1, 0, 2'd0, 3'd0,
                pack(8 * k, 400, 264, 1, k == 8, 0, k == 8));
        add("idle_quiet",   0, 0, 0, 2'd0, 3'd0, pack(64, 400, 264, 1, 0, 0, 1));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].tick, vecs[i].valid, vecs[i].op, vecs[i].idx);
            check(vecs[i].name, dut_outs(), vecs[i].exp);
        end

        // ---- idle bob: 400 for ticks 1-16, 402 for 17-32, 400 again ----
        for (int k = 1; k <= 48; k++) begin
            apply(0, 1, 0, 2'd0, 3'd0);
            check($sformatf("bob_%0d", k), dut_outs(),
                  pack(64, (k >= 17 && k <= 32) ? 402 : 400, 264, 1, 0, 0, 1));
        end

        // ---- faint with bob phase high: first tick snaps back to 400 ----
        apply(0, 0, 1, 2'd2, 3'd0);
        check("faint_accept", dut_outs(), pack(64, 400, 264, 1, 0, 0, 0));
        apply(0, 1, 0, 2'd0, 3'd0);
        check("faint_apply", dut_outs(), pack(64, 400, 264, 1, 0, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            apply(0, 1, 0, 2'd0, 3'd0);
            check($sformatf("faint_%0d", k), dut_outs(),
                  pack(64, 400 + 8 * k, 264, k < 8, k == 8, 0, k == 8));
        end

        // ---- command on the tick cycle waits a whole frame ----
        apply(0, 1, 1, 2'd1, 3'd1);
        check("cmd_on_tick", dut_outs(), pack(64, 464, 264, 0, 0, 0, 0));
        apply(0, 0, 1, 2'd1, 3'd4);
        check("second_blocked", dut_outs(), pack(64, 464, 264, 0, 0, 0, 0));
        apply(0, 1, 0, 2'd0, 3'd0);
        check("late_apply", dut_outs(), pack(0, 400, 132, 1, 0, 0, 0));

        // ---- reset at slide step 4 aborts without done ----
        for (int k = 1; k <= 4; k++) begin
            apply(0, 1, 0, 2'd0, 3'd0);
            check($sformatf("slide2_%0d", k), dut_outs(), pack(8 * k, 400, 132, 1, 0, 0, 0));
        end
        apply(1, 1, 0, 2'd0, 3'd0);
        check("mid_reset", dut_outs(), pack(0, 0, 0, 0, 0, 0, 1));
        apply(0, 0, 0, 2'd0, 3'd0);
        check("post_reset", dut_outs(), pack(0, 0, 0, 0, 0, 0, 1));

        // ---- randomized stimulus against the reference model ----
        apply(1, 0, 0, 2'd0, 3'd0);
        model_reset();
        begin
            bit prev_t = 0;
            for (int c = 0; c < 4000; c++) begin
                bit r, t, v;
                int op, idx;
                r   = ($urandom_range(0, 499) == 0);
                t   = !prev_t && ($urandom_range(0, 2) == 0);
                v   = ($urandom_range(0, 4) == 0);
                op  = int'($urandom_range(0, 3));
                idx = int'($urandom_range(0, 7));
                rst_in       = r;
                cmd_valid_in = v;
                cmd_op_in    = 2'(op);
                cmd_index_in = 3'(idx);
                hcount_in    = t ? 11'd0 : 11'd5;
                vcount_in    = t ? 10'd768 : 10'd0;
                model_step(r, t, v, op, idx);
                @(posedge pixel_clk_in);
                #1;
                check("rand_cycle", dut_outs(),
                      pack(m_x, m_y, m_selx, m_vis, m_done, m_err, m_ready));
                prev_t = t;
            end
        end
        rst_in = 1'b0; cmd_valid_in = 1'b0; hcount_in = 11'd5; vcount_in = 10'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
